// File: rtl/sm4_out_serializer_if.sv
// Byte-stream handshake between the SM4 output serializer and the
// UART/transmit path. The serializer is the master and drives data/valid;
// the sink answers with ready.
interface sm4_out_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/sm4_out_serializer.sv
// SM4 output serializer: captures a result block on the rising edge of
// one_round_ok into a single-entry pending slot, then streams it MSB byte
// first over a valid/ready byte interface. Tracks completed blocks against
// the expected message length and flags dropped captures.
module sm4_out_serializer #(
    parameter int DATA_W = 384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] sm4_dout_i,
    input  logic              one_round_ok,
    input  logic [31:0]       all_group_num,
    sm4_out_serializer_if.master tx,
    output logic              send_ok,
    output logic              out_ok,
    output logic [31:0]       group_cnt,
    output logic              all_sent,
    output logic              overflow
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                rok_r;
    logic                pend_vld_r;
    logic [DATA_W-1:0]   pend_data_r;
    logic [DATA_W-1:0]   shreg_r;
    logic [BCW-1:0]      byte_cnt_r;
    logic                tx_valid_r;
    logic                send_ok_r;
    logic                out_ok_r;
    logic [31:0]         group_cnt_r;
    logic                all_sent_r;
    logic                overflow_r;

    logic                capture_s;
    logic                load_s;
    logic                accept_s;
    logic                drop_s;
    logic                write_s;
    logic                pend_vld_s;

    // Next-state logic: decide when to load the shift register and advance.
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pend_vld_r) begin
                    load_s  = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                accept_s = tx.tx_ready;
                if (tx.tx_ready && (byte_cnt_r == LAST_BYTE)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                // A block already waiting starts right away: no idle gap.
                if (pend_vld_r) begin
                    load_s  = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Capture/drop decode for the single-entry pending slot.
    always_comb begin
        capture_s = one_round_ok & ~rok_r;
        // A drain in the same cycle frees the slot, so the capture is kept.
        drop_s    = capture_s & pend_vld_r & ~load_s;
        write_s   = capture_s & ~drop_s;
        if (capture_s) begin
            pend_vld_s = 1'b1;
        end else if (load_s) begin
            pend_vld_s = 1'b0;
        end else begin
            pend_vld_s = pend_vld_r;
        end
    end

    // FSM state register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tx_valid_r <= 1'b0;
            send_ok_r  <= 1'b0;
            out_ok_r   <= 1'b1;
        end else begin
            state_r    <= state_s;
            tx_valid_r <= (state_s == ST_SEND);
            send_ok_r  <= (state_s == ST_DONE);
            out_ok_r   <= ~pend_vld_s;
        end
    end

    // Edge detector and pending slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rok_r       <= 1'b0;
            pend_vld_r  <= 1'b0;
            pend_data_r <= '0;
        end else begin
            rok_r      <= one_round_ok;
            pend_vld_r <= pend_vld_s;
            if (write_s) begin
                pend_data_r <= sm4_dout_i;
            end else begin
                pend_data_r <= pend_data_r;
            end
        end
    end

    // Shift register and byte counter: load on drain, shift on each accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r    <= '0;
            byte_cnt_r <= '0;
        end else if (load_s) begin
            shreg_r    <= pend_data_r;
            byte_cnt_r <= '0;
        end else if (accept_s) begin
            shreg_r    <= shreg_r << 8;
            byte_cnt_r <= byte_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
        end else begin
            shreg_r    <= shreg_r;
            byte_cnt_r <= byte_cnt_r;
        end
    end

    // Message bookkeeping: block count, end-of-message and drop flags; clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            group_cnt_r <= 32'd0;
            all_sent_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (clr) begin
            group_cnt_r <= 32'd0;
            all_sent_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (state_r == ST_DONE) begin
                group_cnt_r <= group_cnt_r + 32'd1;
                if ((group_cnt_r + 32'd1 == all_group_num) && (all_group_num != 32'd0)) begin
                    all_sent_r <= 1'b1;
                end else begin
                    all_sent_r <= all_sent_r;
                end
            end else begin
                group_cnt_r <= group_cnt_r;
                all_sent_r  <= all_sent_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign tx.tx_data  = shreg_r[DATA_W-1 -: 8];
    assign tx.tx_valid = tx_valid_r;
    assign send_ok     = send_ok_r;
    assign out_ok      = out_ok_r;
    assign group_cnt   = group_cnt_r;
    assign all_sent    = all_sent_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_sm4_out_serializer.sv
// Scoreboard bench for sm4_out_serializer: stimulus pushes the bytes each
// accepted block must produce; a negedge monitor pops and compares every
// transferred byte and checks handshake rules and the send_ok pulse.
module tb_sm4_out_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic [383:0] sm4_dout_i = '0;
    logic         one_round_ok = 1'b0;
    logic [31:0]  all_group_num = 32'd100;
    logic         send_ok;
    logic         out_ok;
    logic [31:0]  group_cnt;
    logic         all_sent;
    logic         overflow;

    sm4_out_serializer_if tx_if();

    sm4_out_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .sm4_dout_i    (sm4_dout_i),
        .one_round_ok  (one_round_ok),
        .all_group_num (all_group_num),
        .tx            (tx_if),
        .send_ok       (send_ok),
        .out_ok        (out_ok),
        .group_cnt     (group_cnt),
        .all_sent      (all_sent),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         mon_idx   = 0;
    bit         so_exp    = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    bit         ready_rand = 1'b0;
    int         exp_gc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [383:0] rand_block();
        logic [383:0] r;
        for (int w = 0; w < 12; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    // Expected byte stream for a block: most significant byte leaves first.
    task automatic push_block(input logic [383:0] d);
        for (int i = 0; i < 48; i++) exp_q.push_back(d[383 - 8*i -: 8]);
    endtask

    // Sink ready: held high, or a fair coin each cycle.
    always @(posedge clk) begin
        #1;
        tx_if.tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: byte scoreboard, stall stability, no mid-block gaps, send_ok timing.
    always @(negedge clk) begin
        if (!rst) begin
            check("send_ok", {63'd0, send_ok}, {63'd0, so_exp});
            if (so_exp) check("valid_low_in_done", {63'd0, tx_if.tx_valid}, 64'd0);
            so_exp = 1'b0;
            if (prev_stall) begin
                check("stall_valid", {63'd0, tx_if.tx_valid}, 64'd1);
                check("stall_data", {56'd0, tx_if.tx_data}, {56'd0, prev_data});
            end
            if (mon_idx != 0) check("valid_mid_block", {63'd0, tx_if.tx_valid}, 64'd1);
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte at %0t", tx_if.tx_data, $time);
                end else begin
                    check("byte", {56'd0, tx_if.tx_data}, {56'd0, exp_q.pop_front()});
                end
                if (mon_idx == 47) begin
                    mon_idx = 0;
                    so_exp  = 1'b1;
                end else begin
                    mon_idx++;
                end
            end
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_data  = tx_if.tx_data;
        end else begin
            mon_idx    = 0;
            so_exp     = 1'b0;
            prev_stall = 1'b0;
            exp_q.delete();
        end
    end

    // Raise one_round_ok for 'hold' cycles; data is only valid on the edge cycle.
    task automatic issue(input logic [383:0] d, input bit accept, input int hold);
        @(posedge clk); #1;
        sm4_dout_i   = d;
        one_round_ok = 1'b1;
        if (accept) push_block(d);
        for (int k = 1; k < hold; k++) begin
            @(posedge clk); #1;
            sm4_dout_i = rand_block();
        end
        @(posedge clk); #1;
        one_round_ok = 1'b0;
        sm4_dout_i   = rand_block();
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        logic [383:0] d;
        logic [383:0] blk_b;
        int guard;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_data", {56'd0, tx_if.tx_data}, 64'd0);
        check("rst_tx_valid", {63'd0, tx_if.tx_valid}, 64'd0);
        check("rst_send_ok", {63'd0, send_ok}, 64'd0);
        check("rst_out_ok", {63'd0, out_ok}, 64'd1);
        check("rst_group_cnt", {32'd0, group_cnt}, 64'd0);
        check("rst_all_sent", {63'd0, all_sent}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single block 0x00..0x2F with latency check
        for (int i = 0; i < 48; i++) d[383 - 8*i -: 8] = 8'(i);
        @(posedge clk); #1;
        sm4_dout_i   = d;
        one_round_ok = 1'b1;
        push_block(d);
        exp_gc++;
        @(negedge clk);
        check("lat_c0_valid", {63'd0, tx_if.tx_valid}, 64'd0);
        @(posedge clk); #1;
        sm4_dout_i = rand_block();
        @(negedge clk);
        check("lat_c1_valid", {63'd0, tx_if.tx_valid}, 64'd0);
        check("lat_c1_out_ok", {63'd0, out_ok}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_c2_valid", {63'd0, tx_if.tx_valid}, 64'd1);
        check("lat_c2_byte0", {56'd0, tx_if.tx_data}, 64'd0);
        check("lat_c2_out_ok", {63'd0, out_ok}, 64'd1);
        @(posedge clk); #1;
        one_round_ok = 1'b0;
        wait_drain(500);
        check("single_group_cnt", {32'd0, group_cnt}, 64'(exp_gc));

        // Random data under random back-pressure, some blocks queued behind others
        ready_rand = 1'b1;
        for (int n = 0; n < 6; n++) begin
            issue(rand_block(), 1'b1, $urandom_range(1, 4));
            exp_gc++;
            if ($urandom_range(0, 1) == 1) begin
                issue(rand_block(), 1'b1, $urandom_range(1, 3));
                exp_gc++;
            end
            wait_drain(3000);
        end
        check("rand_group_cnt", {32'd0, group_cnt}, 64'(exp_gc));
        check("rand_overflow", {63'd0, overflow}, 64'd0);
        check("rand_all_sent", {63'd0, all_sent}, 64'd0);

        // Pending, back-to-back and overflow with ready held high
        ready_rand = 1'b0;
        @(posedge clk);
        issue(rand_block(), 1'b1, 3);
        @(posedge clk);
        blk_b = rand_block();
        issue(blk_b, 1'b1, 2);
        @(negedge clk);
        check("b_pending_out_ok", {63'd0, out_ok}, 64'd0);
        repeat (8) @(posedge clk);
        issue(rand_block(), 1'b0, 2);
        @(negedge clk);
        check("c_overflow", {63'd0, overflow}, 64'd1);
        check("c_out_ok", {63'd0, out_ok}, 64'd0);
        guard = 0;
        while (send_ok !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("a_done_seen", {63'd0, send_ok}, 64'd1);
        @(negedge clk);
        check("b_b2b_valid", {63'd0, tx_if.tx_valid}, 64'd1);
        check("b_b2b_byte0", {56'd0, tx_if.tx_data}, {56'd0, blk_b[383:376]});
        check("b_drained_out_ok", {63'd0, out_ok}, 64'd1);
        exp_gc += 2;
        wait_drain(500);
        check("ovf_group_cnt", {32'd0, group_cnt}, 64'(exp_gc));

        // All sent over a three-block message
        pulse_clr();
        exp_gc = 0;
        all_group_num = 32'd3;
        ready_rand = 1'b1;
        for (int n = 0; n < 3; n++) begin
            issue(rand_block(), 1'b1, 2);
            exp_gc++;
            wait_drain(3000);
            check("msg_group_cnt", {32'd0, group_cnt}, 64'(exp_gc));
            check("msg_all_sent", {63'd0, all_sent}, (n == 2) ? 64'd1 : 64'd0);
        end
        pulse_clr();
        @(negedge clk);
        check("clr_group_cnt", {32'd0, group_cnt}, 64'd0);
        check("clr_all_sent", {63'd0, all_sent}, 64'd0);
        check("clr_overflow", {63'd0, overflow}, 64'd0);

        // Mid-block reset
        ready_rand = 1'b0;
        all_group_num = 32'd100;
        issue(rand_block(), 1'b1, 2);
        wait_drain(500);
        check("pre_rst_group_cnt", {32'd0, group_cnt}, 64'd1);
        issue(rand_block(), 1'b1, 2);
        guard = 0;
        while (mon_idx < 21 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reached_byte20", 64'(mon_idx >= 21), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_valid", {63'd0, tx_if.tx_valid}, 64'd0);
        check("midrst_group_cnt", {32'd0, group_cnt}, 64'd0);
        check("midrst_out_ok", {63'd0, out_ok}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        issue(d, 1'b1, 2);
        wait_drain(500);
        check("post_rst_group_cnt", {32'd0, group_cnt}, 64'd1);
        check("post_rst_overflow", {63'd0, overflow}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
